// File: rtl/dk_sfx_trigger_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dk_sfx_trigger_scheduler
//
// Turns CPU sound-latch writes into per-effect enables (e.g. walk_en) for the
// discrete sound datapaths. Each channel enforces a minimum on-time, so a
// short trigger still plays its full envelope. Each channel also enforces a
// minimum off-time, so the analog filters recover before the next trigger.
// Channel state machines advance only on audio_clk_en.
//
// Ports:
//   clk          system clock
//   I_RSTn       asynchronous active-low reset
//   audio_clk_en one-cycle sample-rate enable
//   cpu_wr       one-cycle latch write strobe
//   cpu_addr     channel select for cpu_wr (addresses >= NUM_CH are ignored)
//   cpu_data     requested level for the selected channel
//   mute         synchronous force of all channels to idle
//   sfx_en       registered enables to the effect datapaths
//   pending      retrigger queued during the off-guard
//   busy         high while any channel is not idle
// ---------------------------------------------------------------------------
module dk_sfx_trigger_scheduler #(
    parameter int  NUM_CH          = 4,
    parameter int  MIN_ON_SAMPLES  = 480,
    parameter int  MIN_OFF_SAMPLES = 96,
    parameter int  CNT_W           = 12,
    localparam int AW              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              I_RSTn,
    input  logic              audio_clk_en,
    input  logic              cpu_wr,
    input  logic [AW-1:0]     cpu_addr,
    input  logic              cpu_data,
    input  logic              mute,
    output logic [NUM_CH-1:0] sfx_en,
    output logic [NUM_CH-1:0] pending,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_HOLD,
        ST_GUARD
    } state_e;

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(MIN_ON_SAMPLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] latch_q;
    logic [NUM_CH-1:0] latch_d;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] sfx_en_q;
    logic [NUM_CH-1:0] sfx_en_d;
    logic              busy_q;
    logic              busy_d;

    // The latch captures on any clk edge and keeps capturing while muted.
    always_comb begin
        latch_d = latch_q;
        if (cpu_wr && (int'(cpu_addr) < NUM_CH)) begin
            latch_d[cpu_addr] = cpu_data;
        end
    end

    // The FSMs look at latch_q, not latch_d. A write on the same edge as
    // audio_clk_en therefore takes effect at the following enable.
    always_comb begin
        sfx_en_d  = '0;
        pending_d = pending_q;
        busy_d    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (mute) begin
                state_d[i]   = ST_IDLE;
                cnt_d[i]     = '0;
                pending_d[i] = 1'b0;
            end else if (audio_clk_en) begin
                unique case (state_q[i])
                    ST_IDLE: begin
                        if (latch_q[i]) begin
                            state_d[i] = ST_ON;
                            cnt_d[i]   = ON_LOAD;
                        end
                    end
                    ST_ON: begin
                        // Latch toggles during ON are ignored until the minimum on-time expires.
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end else if (latch_q[i]) begin
                            state_d[i] = ST_HOLD;
                        end else begin
                            state_d[i] = ST_GUARD;
                            cnt_d[i]   = OFF_LOAD;
                        end
                    end
                    ST_HOLD: begin
                        if (!latch_q[i]) begin
                            state_d[i] = ST_GUARD;
                            cnt_d[i]   = OFF_LOAD;
                        end
                    end
                    ST_GUARD: begin
                        // A request seen during the guard is remembered even if the
                        // latch drops again before the guard expires.
                        if (cnt_q[i] != '0) begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                            if (latch_q[i]) begin
                                pending_d[i] = 1'b1;
                            end
                        end else if (pending_q[i] || latch_q[i]) begin
                            state_d[i]   = ST_ON;
                            cnt_d[i]     = ON_LOAD;
                            pending_d[i] = 1'b0;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                    end
                endcase
            end
            // Outputs are decoded from next state so they register alongside it.
            sfx_en_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_HOLD);
            busy_d      = busy_d | (state_d[i] != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            latch_q   <= '0;
            pending_q <= '0;
            sfx_en_q  <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            latch_q   <= latch_d;
            pending_q <= pending_d;
            sfx_en_q  <= sfx_en_d;
            busy_q    <= busy_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign sfx_en  = sfx_en_q;
    assign pending = pending_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_dk_sfx_trigger_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_dk_sfx_trigger_scheduler
//
// Scoreboard bench. Each stimulus cycle steps a behavioural model and queues
// the expected {sfx_en, pending, busy}. A monitor pops one entry per clock
// and compares it shortly after the edge. The model tracks each channel as
// idle / sounding / guarding. It counts elapsed samples in the current phase.
// ---------------------------------------------------------------------------
module tb_dk_sfx_trigger_scheduler;

    localparam int NUM_CH  = 4;
    localparam int MIN_ON  = 4;
    localparam int MIN_OFF = 2;
    localparam int CNT_W   = 4;
    localparam int AW      = 2;
    localparam int EW      = 2 * NUM_CH + 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_SOUND = 1;
    localparam int PH_GUARD = 2;

    logic              clk          = 1'b0;
    logic              I_RSTn       = 1'b0;
    logic              audio_clk_en = 1'b0;
    logic              cpu_wr       = 1'b0;
    logic [AW-1:0]     cpu_addr     = '0;
    logic              cpu_data     = 1'b0;
    logic              mute         = 1'b0;
    logic [NUM_CH-1:0] sfx_en;
    logic [NUM_CH-1:0] pending;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [EW-1:0] exp_q[$];

    int m_phase   [NUM_CH];
    int m_elapsed [NUM_CH];
    bit m_pend    [NUM_CH];
    bit m_latch   [NUM_CH];
    int on_samples[NUM_CH];

    always #5 clk = ~clk;

    dk_sfx_trigger_scheduler #(
        .NUM_CH         (NUM_CH),
        .MIN_ON_SAMPLES (MIN_ON),
        .MIN_OFF_SAMPLES(MIN_OFF),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .I_RSTn      (I_RSTn),
        .audio_clk_en(audio_clk_en),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .mute        (mute),
        .sfx_en      (sfx_en),
        .pending     (pending),
        .busy        (busy)
    );

    function automatic void resetModel();
        for (int i = 0; i < NUM_CH; i++) begin
            m_phase[i]   = PH_IDLE;
            m_elapsed[i] = 0;
            m_pend[i]    = 1'b0;
            m_latch[i]   = 1'b0;
        end
    endfunction

    // One clock edge of the model. The phases use the latch value from before this edge's write.
    function automatic void modelStep(bit wr, int addr, bit data, bit en, bit mt);
        if (!I_RSTn) begin
            resetModel();
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (mt) begin
                m_phase[i]   = PH_IDLE;
                m_elapsed[i] = 0;
                m_pend[i]    = 1'b0;
            end else if (en) begin
                case (m_phase[i])
                    PH_IDLE: begin
                        if (m_latch[i]) begin
                            m_phase[i]   = PH_SOUND;
                            m_elapsed[i] = 1;
                        end
                    end
                    PH_SOUND: begin
                        if (m_elapsed[i] < MIN_ON) begin
                            m_elapsed[i]++;
                        end else if (!m_latch[i]) begin
                            m_phase[i]   = PH_GUARD;
                            m_elapsed[i] = 1;
                        end
                    end
                    PH_GUARD: begin
                        if (m_latch[i]) m_pend[i] = 1'b1;
                        if (m_elapsed[i] < MIN_OFF) begin
                            m_elapsed[i]++;
                        end else if (m_pend[i]) begin
                            m_phase[i]   = PH_SOUND;
                            m_elapsed[i] = 1;
                            m_pend[i]    = 1'b0;
                        end else begin
                            m_phase[i]   = PH_IDLE;
                            m_elapsed[i] = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (wr && addr < NUM_CH) m_latch[addr] = data;
    endfunction

    function automatic logic [EW-1:0] modelExpect();
        logic [NUM_CH-1:0] s;
        logic [NUM_CH-1:0] p;
        logic              b;
        s = '0;
        p = '0;
        b = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            s[i] = (m_phase[i] == PH_SOUND);
            p[i] = m_pend[i];
            b    = b | (m_phase[i] != PH_IDLE);
        end
        return {s, p, b};
    endfunction

    task automatic checkOutput(input string name, input logic [EW-1:0] exp);
        logic [EW-1:0] got;
        got = {sfx_en, pending, busy};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0t: got sfx_en=%b pending=%b busy=%b, expected sfx_en=%b pending=%b busy=%b",
                     name, $time, got[EW-1 -: NUM_CH], got[NUM_CH:1], got[0],
                     exp[EW-1 -: NUM_CH], exp[NUM_CH:1], exp[0]);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s t=%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Drive one clock's worth of inputs just after an edge, and queue the expected outputs after the next edge.
    task automatic applyStimulus(input bit wr, input int addr, input bit data, input bit en, input bit mt);
        @(posedge clk);
        #1;
        if (audio_clk_en && I_RSTn) begin
            for (int i = 0; i < NUM_CH; i++) if (sfx_en[i]) on_samples[i]++;
        end
        cpu_wr       = wr;
        cpu_addr     = AW'(addr);
        cpu_data     = data;
        audio_clk_en = en;
        mute         = mt;
        modelStep(wr, addr, data, en, mt);
        exp_q.push_back(modelExpect());
    endtask

    // Directed traffic: an audio enable every third clock.
    task automatic tick(input bit wr, input int addr, input bit data, input bit mt);
        applyStimulus(wr, addr, data, (cyc % 3) == 2, mt);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic alignToWrite();
        while ((cyc % 3) != 0) idle(1);
    endtask

    // Monitor: any entry queued before this edge describes the state after this edge.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                #3;
                checkOutput("scoreboard", e);
            end
        end
    end

    initial begin
        resetModel();
        for (int i = 0; i < NUM_CH; i++) on_samples[i] = 0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_values", '0);
        I_RSTn = 1'b1;

        // Long trigger with HOLD, then release through GUARD back to IDLE.
        alignToWrite();
        tick(1'b1, 0, 1'b1, 1'b0);
        idle(24);
        tick(1'b1, 0, 1'b0, 1'b0);
        idle(15);

        // Pulse that never reaches an enable: nothing plays.
        alignToWrite();
        on_samples[1] = 0;
        tick(1'b1, 1, 1'b1, 1'b0);
        tick(1'b1, 1, 1'b0, 1'b0);
        idle(20);
        checkCount("short_pulse_ignored", on_samples[1], 0);

        // Pulse spanning one enable: exactly MIN_ON samples.
        alignToWrite();
        on_samples[1] = 0;
        tick(1'b1, 1, 1'b1, 1'b0);
        idle(3);
        tick(1'b1, 1, 1'b0, 1'b0);
        idle(30);
        checkCount("min_on_time", on_samples[1], MIN_ON);

        // Retrigger pulse inside the guard is queued and replayed.
        alignToWrite();
        on_samples[2] = 0;
        tick(1'b1, 2, 1'b1, 1'b0);
        idle(2);
        tick(1'b1, 2, 1'b0, 1'b0);
        idle(11);
        tick(1'b1, 2, 1'b1, 1'b0);
        idle(2);
        tick(1'b1, 2, 1'b0, 1'b0);
        checkCount("guard_pending", int'(pending[2]), 1);
        idle(30);
        checkCount("guard_retrigger_samples", on_samples[2], 2 * MIN_ON);

        // Write coinciding with an enable edge on the same channel.
        alignToWrite();
        applyStimulus(1'b1, 3, 1'b1, 1'b1, 1'b0);
        idle(10);
        tick(1'b1, 3, 1'b0, 1'b0);
        idle(30);

        // Write to ch0 on an edge where ch1 is advancing.
        alignToWrite();
        tick(1'b1, 1, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b1, 0, 1'b1, 1'b1, 1'b0);
        idle(6);
        tick(1'b1, 0, 1'b0, 1'b0);
        tick(1'b1, 1, 1'b0, 1'b0);
        idle(30);

        // Mute during ON with latch still high; the channel restarts afterwards.
        alignToWrite();
        tick(1'b1, 0, 1'b1, 1'b0);
        idle(5);
        tick(1'b0, 0, 1'b0, 1'b1);
        idle(1);
        checkCount("mute_forces_off", int'(sfx_en[0]), 0);
        idle(12);
        tick(1'b1, 0, 1'b0, 1'b0);
        idle(30);

        // Asynchronous reset while every channel is active.
        for (int i = 0; i < NUM_CH; i++) tick(1'b1, i, 1'b1, 1'b0);
        idle(6);
        @(posedge clk);
        #5;
        I_RSTn = 1'b0;
        #1;
        checkOutput("async_reset", '0);
        resetModel();
        tick(1'b1, 0, 1'b1, 1'b0);
        tick(1'b1, 2, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
        I_RSTn = 1'b1;
        idle(30);
        checkCount("no_output_after_reset", int'(busy), 0);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            applyStimulus(($urandom % 4) == 0, int'($urandom % NUM_CH), 1'($urandom),
                          ($urandom % 3) == 0, ($urandom % 100) == 0);
        end

        @(posedge clk);
        #5;
        checkCount("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dk_sfx_trigger_scheduler.md
Name: dk_sfx_trigger_scheduler

Overview:
Sequences the enable inputs of the discrete sound-effect datapaths, such as the walk circuit's walk_en, from CPU sound-latch writes. Each effect has a register and a small state machine. The state machine enforces a minimum on-time, so a retriggered enable still runs its full filter/VCO envelope. It also enforces a minimum off-time, so the slew limiter and the RC filters recover before the next trigger. Sits between the CPU sound-latch decode and the per-effect discrete modules, in the clk domain, and advances on audio_clk_en.

Parameters:
NUM_CH, 4, number of effect channels (bit i drives effect i).
MIN_ON_SAMPLES, 480, minimum enable-asserted time in audio samples (10 ms at 48 kHz); must be >= 1.
MIN_OFF_SAMPLES, 96, minimum enable-deasserted guard time in audio samples; must be >= 1.
CNT_W, 12, per-channel counter width; must hold max(MIN_ON_SAMPLES, MIN_OFF_SAMPLES) - 1.

Ports:
clk  in  1  system clock
I_RSTn  in  1  asynchronous active-low reset
audio_clk_en  in  1  one-cycle sample-rate enable
cpu_wr  in  1  one-cycle latch write strobe
cpu_addr  in  $clog2(NUM_CH)  channel select for cpu_wr
cpu_data  in  1  requested level for the selected channel
mute  in  1  synchronous force of all channels to idle
sfx_en  out  NUM_CH  registered enables to the effect datapaths
pending  out  NUM_CH  retrigger queued during the off-guard
busy  out  1  OR of all channels not IDLE

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on I_RSTn.
- Reset values: latch = 0; every channel in IDLE; counters = 0; sfx_en = 0; pending = 0; busy = 0.
- Latch capture:
  - On cpu_wr, latch[cpu_addr] <= cpu_data on that clk edge, whether or not audio_clk_en is high.
  - cpu_addr >= NUM_CH is ignored.
- FSM timing:
  - FSMs change state only on clk edges where audio_clk_en = 1.
  - They sample the registered latch value, so a write in the same cycle as audio_clk_en is seen at the next enable.
- Per-channel states:
  - IDLE: if latch = 1, go to ON and load cnt = MIN_ON_SAMPLES-1.
  - ON: if cnt != 0, decrement cnt. If cnt = 0 and latch = 1, go to HOLD. If cnt = 0 and latch = 0, go to GUARD and load cnt = MIN_OFF_SAMPLES-1.
  - HOLD: if latch = 0, go to GUARD and load cnt = MIN_OFF_SAMPLES-1.
  - GUARD:
    - If latch = 1 at any enable, set pending.
    - If cnt != 0, decrement cnt.
    - If cnt = 0: when pending or latch = 1, go to ON, load MIN_ON_SAMPLES-1 and clear pending; otherwise go to IDLE.
- Outputs:
  - sfx_en[i] = 1 exactly while channel i is in ON or HOLD. It is registered with the state, so it changes on the same enable edge as the state.
  - A trigger written while IDLE gives sfx_en high on the second audio_clk_en after the write, or on the first if the write preceded that enable by at least one clk.
- On-time rules:
  - A latch pulse shorter than MIN_ON_SAMPLES still yields exactly MIN_ON_SAMPLES samples of sfx_en.
  - A 1->0->1 toggle during ON is ignored: no restart, no extension.
- Off-time rule: sfx_en stays low for at least MIN_OFF_SAMPLES samples between assertions.
- Channel independence: channels are fully independent; there is no cross-channel priority.
- Mute:
  - mute = 1 on any clk edge forces all channels to IDLE, clears cnt and pending, and drives sfx_en = 0 on the next edge.
  - Latch writes are still captured while mute is high.
  - After mute releases, a channel whose latch = 1 retriggers from IDLE at the next enable.
- Reset mid-operation: asynchronous return to reset values; no partial envelope completes.

Test Plan:
1. MIN_ON=4, MIN_OFF=2. Write ch0=1, then 8 enables later write ch0=0 -> sfx_en[0] high from enable 1 through the enable on which latch=0 is sampled (HOLD->GUARD), then low for 2 enables -> IDLE; busy then low.
2. Short pulse: write ch1=1, then ch1=0 one clk later (before any enable) -> channel stays IDLE, sfx_en[1] never asserts. Repeat with the 0 write after the first enable -> sfx_en[1] high for exactly 4 enables.
3. Retrigger in guard: ch2 enters GUARD, write ch2=1 then ch2=0 within the guard -> pending[2]=1, then on guard expiry sfx_en[2] reasserts for 4 enables; pending[2] cleared.
4. Simultaneous events:
   - Write ch3=1 on the same clk as audio_clk_en -> no state change that enable; ON at the next enable.
   - Write ch0 and a ch1 enable edge in the same cycle -> both handled independently.
5. Mute: assert mute for 1 clk while ch0 is in ON with cnt=2 and latch=1 -> sfx_en[0]=0 on the next clk; ON resumes (cnt reloaded to 3) at the following enable.
6. Reset mid-operation: drop I_RSTn while all 4 channels are active -> all outputs 0 immediately (asynchronous), latch cleared. After release, no output until a new write.
